maxnet_iter_ctrl: RTL and testbench

- Sequencer on the driving side of the Maxnet output-check interface.
- Accepts four 32-bit float neuron activations with their 32-bit labels over a valid/ready stream and holds them in lane registers.
- Presents the lanes to the output checker, which returns chk_valid and a registered winner label.
- While the checker is not satisfied, requests one Maxnet update per iteration from the external neuron datapath and loads the results back into the lanes. Reports winner, all-zero or timeout on a result handshake.

---
 rtl/maxnet_pkg.sv | 30 +++
 rtl/maxnet_lane_bank.sv | 39 +++
 rtl/maxnet_iter_ctrl.sv | 147 ++++++++++++++
 tb/tb_maxnet_iter_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// rtl/maxnet_pkg.sv - shared types, constants and lane helpers for the Maxnet sequencer
// Contents:
//   DW, LANES     lane data width and lane count
//   state_t       sequencer states
//   ST_*          result status codes
//   lane_is_zero  float zero test on magnitude bits only
package maxnet_pkg;

    localparam int DW    = 32;
    localparam int LANES = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EVAL,
        CAPTURE,
        UPDATE,
        DONE
    } state_t;

    localparam logic [1:0] ST_WIN     = 2'd0;
    localparam logic [1:0] ST_ALLZERO = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    // Sign bit is ignored so that -0.0 counts as a zero lane.
    function automatic logic lane_is_zero(input logic [DW-1:0] v);
        return (v[30:0] == 31'd0);
    endfunction

endpackage

// File: rtl/maxnet_lane_bank.sv
// rtl/maxnet_lane_bank.sv - four activation and four label lane registers
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   load_en, load_idx     write one lane of x and a from load_data/load_label
//   bulk_en, bulk_x       overwrite all x lanes at once (labels untouched)
//   x_bus, a_bus          lane i at [DW*i+DW-1:DW*i]
module maxnet_lane_bank #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  logic [1:0]      load_idx,
    input  logic [DW-1:0]   load_data,
    input  logic [DW-1:0]   load_label,
    input  logic            bulk_en,
    input  logic [4*DW-1:0] bulk_x,
    output logic [4*DW-1:0] x_bus,
    output logic [4*DW-1:0] a_bus
);
    import maxnet_pkg::*;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_bus <= '0;
            a_bus <= '0;
        end else if (load_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (load_idx == i[1:0]) begin
                    x_bus[i*DW +: DW] <= load_data;
                    a_bus[i*DW +: DW] <= load_label;
                end
            end
        end else if (bulk_en) begin
            x_bus <= bulk_x;
        end
    end

endmodule

// File: rtl/maxnet_iter_ctrl.sv
// rtl/maxnet_iter_ctrl.sv - Maxnet load / check / update sequencer
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_label  four load beats, beat k fills lane k
//   x_bus, a_bus                     lanes presented to the output checker
//   chk_valid, chk_out               checker verdict and registered winner label
//   upd_start, upd_done, upd_x_bus   one Maxnet update request / response
//   res_valid/res_ready              result handshake
//   res_label, res_status, res_iter  winner label, WIN/ALLZERO/TIMEOUT, updates done
module maxnet_iter_ctrl #(
    parameter int DW       = 32,
    parameter int MAX_ITER = 64,
    parameter int ITER_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic [DW-1:0]     in_label,
    output logic [4*DW-1:0]   x_bus,
    output logic [4*DW-1:0]   a_bus,
    input  logic              chk_valid,
    input  logic [DW-1:0]     chk_out,
    output logic              upd_start,
    input  logic              upd_done,
    input  logic [4*DW-1:0]   upd_x_bus,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DW-1:0]     res_label,
    output logic [1:0]        res_status,
    output logic [ITER_W-1:0] res_iter
);
    import maxnet_pkg::*;

    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

    state_t            state;
    logic [1:0]        load_cnt;
    logic [ITER_W-1:0] iter_cnt;
    logic              load_en;
    logic              bulk_en;
    logic              all_zero;

    // in_ready is only high in IDLE/LOAD, so a beat can never land elsewhere.
    assign load_en = in_valid && in_ready;
    // upd_done is honoured only while waiting for it; stray pulses are dropped.
    assign bulk_en = (state == UPDATE) && upd_done;

    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            all_zero &= lane_is_zero(x_bus[i*DW +: DW]);
        end
    end

    maxnet_lane_bank #(.DW(DW)) u_lanes (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_idx   (load_cnt),
        .load_data  (in_data),
        .load_label (in_label),
        .bulk_en    (bulk_en),
        .bulk_x     (upd_x_bus),
        .x_bus      (x_bus),
        .a_bus      (a_bus)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            upd_start  <= 1'b0;
            res_valid  <= 1'b0;
            res_label  <= '0;
            res_status <= ST_WIN;
            res_iter   <= '0;
            load_cnt   <= '0;
            iter_cnt   <= '0;
        end else begin
            upd_start <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    if (load_en) begin
                        load_cnt <= load_cnt + 2'd1;
                        if (load_cnt == 2'd3) begin
                            state    <= EVAL;
                            in_ready <= 1'b0;
                            iter_cnt <= '0;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                EVAL: begin
                    if (chk_valid && all_zero) begin
                        state      <= DONE;
                        res_valid  <= 1'b1;
                        res_status <= ST_ALLZERO;
                        res_label  <= '0;
                        res_iter   <= iter_cnt;
                    end else if (chk_valid) begin
                        // chk_out only reflects these lanes one edge later.
                        state <= CAPTURE;
                    end else if (iter_cnt == ITER_MAX) begin
                        state      <= DONE;
                        res_valid  <= 1'b1;
                        res_status <= ST_TIMEOUT;
                        res_label  <= '0;
                        res_iter   <= iter_cnt;
                    end else begin
                        state     <= UPDATE;
                        upd_start <= 1'b1;
                    end
                end
                CAPTURE: begin
                    state      <= DONE;
                    res_valid  <= 1'b1;
                    res_status <= ST_WIN;
                    res_label  <= chk_out;
                    res_iter   <= iter_cnt;
                end
                UPDATE: begin
                    if (upd_done) begin
                        state <= EVAL;
                        if (iter_cnt != ITER_MAX) begin
                            iter_cnt <= iter_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_iter_ctrl.sv
// tb/tb_maxnet_iter_ctrl.sv - self-checking bench for maxnet_iter_ctrl
module tb_maxnet_iter_ctrl;

    localparam int MAXI = 4;
    localparam int IW   = 7;

    typedef logic [3:0][31:0] lanes_t;
    typedef struct {
        lanes_t      x;
        lanes_t      a;
        int          mode;
        int          dly;
        logic [1:0]  st;
        logic [31:0] lbl;
        int          it;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic [31:0]   in_label;
    logic [127:0]  x_bus;
    logic [127:0]  a_bus;
    logic          chk_valid;
    logic [31:0]   chk_out = 32'd0;
    logic          upd_start;
    logic          upd_done = 1'b0;
    logic [127:0]  upd_x_bus = '0;
    logic          res_valid;
    logic          res_ready;
    logic [31:0]   res_label;
    logic [1:0]    res_status;
    logic [IW-1:0] res_iter;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int upd_cnt = 0;
    int upd_trig = 0;
    int beat_trig = 0;
    int rsp_mode = 0;
    int rsp_dly = 0;
    int pend = 0;
    logic [31:0] win_lbl;

    maxnet_iter_ctrl #(.DW(32), .MAX_ITER(MAXI), .ITER_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_label   (in_label),
        .x_bus      (x_bus),
        .a_bus      (a_bus),
        .chk_valid  (chk_valid),
        .chk_out    (chk_out),
        .upd_start  (upd_start),
        .upd_done   (upd_done),
        .upd_x_bus  (upd_x_bus),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_label  (res_label),
        .res_status (res_status),
        .res_iter   (res_iter)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output checker: valid when 3 or 4 lanes are zero, registered winner label.
    always_comb begin
        int z;
        z = 0;
        win_lbl = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (x_bus[i*32 +: 31] == 31'd0) z++;
            else win_lbl = a_bus[i*32 +: 32];
        end
        chk_valid = (z >= 3);
        if (z != 3) win_lbl = 32'd0;
    end
    always @(posedge clk) chk_out <= win_lbl;

    function automatic lanes_t mk(input logic [31:0] l0, l1, l2, l3);
        lanes_t r;
        r[0] = l0; r[1] = l1; r[2] = l2; r[3] = l3;
        return r;
    endfunction

    function automatic int nzero(input lanes_t x);
        int z = 0;
        for (int i = 0; i < 4; i++) if (x[i][30:0] == 31'd0) z++;
        return z;
    endfunction

    // mode 0: zero smallest nonzero lane, 1: unchanged, 2: zero largest, 3: junk pattern
    function automatic lanes_t apply_upd(input lanes_t x, input int mode);
        lanes_t r;
        int idx;
        r = x;
        idx = -1;
        if (mode == 3) return {4{32'h12345678}};
        if (mode == 0 || mode == 2) begin
            for (int i = 0; i < 4; i++) begin
                if (x[i][30:0] != 31'd0) begin
                    if (idx < 0) idx = i;
                    else if (mode == 0 && x[i][30:0] < x[idx][30:0]) idx = i;
                    else if (mode == 2 && x[i][30:0] > x[idx][30:0]) idx = i;
                end
            end
        end
        if (idx >= 0) r[idx] = 32'd0;
        return r;
    endfunction

    task automatic ref_model(input lanes_t x0, input lanes_t a, input int mode,
                             output logic [1:0] st, output logic [31:0] lbl,
                             output int it, output lanes_t xf);
        lanes_t x;
        bit done;
        x = x0; it = 0; done = 0; st = 2'd0; lbl = 32'd0;
        while (!done) begin
            if (nzero(x) == 4) begin
                st = 2'd1; lbl = 32'd0; done = 1;
            end else if (nzero(x) == 3) begin
                st = 2'd0; done = 1;
                for (int i = 0; i < 4; i++) if (x[i][30:0] != 31'd0) lbl = a[i];
            end else if (it == MAXI) begin
                st = 2'd2; lbl = 32'd0; done = 1;
            end else begin
                x = apply_upd(x, mode);
                it++;
            end
        end
        xf = x;
    endtask

    // Update responder: answers each upd_start after rsp_dly cycles (0 = same cycle).
    always @(negedge clk) begin
        bit f;
        f = 0;
        upd_done = 1'b0;
        if (upd_start === 1'b1) begin
            upd_cnt++;
            if (rsp_dly == 0) f = 1;
            else pend = rsp_dly;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) f = 1;
        end
        if (f) begin
            upd_x_bus = apply_upd(x_bus, rsp_mode);
            upd_done = 1'b1;
            upd_trig = cyc + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load(input lanes_t x, input lanes_t a, input int gap);
        int t;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap)) @(negedge clk);
            in_valid = 1'b1;
            in_data = x[k];
            in_label = a[k];
            t = 0;
            while (in_ready !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (in_ready !== 1'b1) begin
                chk("load_in_ready", {31'd0, in_ready}, 32'd1);
                in_valid = 1'b0;
                return;
            end
            beat_trig = cyc + 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input string nm);
        int t = 0;
        while (res_valid !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("%s.res_valid", nm), {31'd0, res_valid}, 32'd1);
    endtask

    task automatic run_txn(input string nm, input lanes_t x, input lanes_t a,
                           input int mode, input int dly, input int rdly, input int gap,
                           input logic [1:0] est, input logic [31:0] elbl, input int eit);
        lanes_t xf;
        logic [1:0] ms;
        logic [31:0] ml;
        int mi, u0, trig;
        ref_model(x, a, mode, ms, ml, mi, xf);
        rsp_mode = mode;
        rsp_dly = dly;
        u0 = upd_cnt;
        load(x, a, gap);
        wait_res(nm);
        if (res_valid !== 1'b1) return;
        trig = (upd_trig > beat_trig) ? upd_trig : beat_trig;
        chk($sformatf("%s.status", nm), {30'd0, res_status}, {30'd0, est});
        chk($sformatf("%s.label", nm), res_label, elbl);
        chk($sformatf("%s.iter", nm), {25'd0, res_iter}, eit);
        chk($sformatf("%s.upd_starts", nm), upd_cnt - u0, eit);
        chk($sformatf("%s.latency", nm), cyc - trig, (est == 2'd0) ? 2 : 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s.a%0d", nm, i), a_bus[i*32 +: 32], a[i]);
            chk($sformatf("%s.x%0d", nm, i), x_bus[i*32 +: 32], xf[i]);
        end
        repeat (rdly) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk($sformatf("%s.res_valid_clr", nm), {31'd0, res_valid}, 32'd0);
        chk($sformatf("%s.in_ready_back", nm), {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[9];
        lanes_t labs, rx, ra, xf;
        logic [1:0] est;
        logic [31:0] elbl, v;
        int eit, u0, t;

        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; in_data = 0; in_label = 0;
        repeat (3) @(negedge clk);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.upd_start", {31'd0, upd_start}, 32'd0);
        chk("rst.res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst.res_label", res_label, 32'd0);
        chk("rst.res_status", {30'd0, res_status}, 32'd0);
        chk("rst.res_iter", {25'd0, res_iter}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("rst.x", x_bus[i*32 +: 32], 32'd0);
            chk("rst.a", a_bus[i*32 +: 32], 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        labs = mk(32'hA, 32'hB, 32'hC, 32'hD);
        vt[0] = '{mk(32'h3F800000, 0, 0, 0), labs, 0, 0, 2'd0, 32'hA, 0};
        vt[1] = '{mk(0, 32'h80000000, 0, 0), labs, 0, 0, 2'd1, 32'h0, 0};
        vt[2] = '{mk(32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h3E000000), labs, 0, 3, 2'd0, 32'hA, 3};
        vt[3] = '{mk(32'h3F800000, 32'h3F000000, 0, 0), labs, 1, 1, 2'd2, 32'h0, 4};
        vt[4] = '{mk(0, 32'h3F800000, 32'h3F000000, 0), labs, 0, 0, 2'd0, 32'hB, 1};
        vt[5] = '{mk(32'h40000000, 32'hBF800000, 32'h3F000000, 0), labs, 2, 2, 2'd0, 32'hC, 2};
        vt[6] = '{mk(32'h80000000, 0, 32'hC0000000, 32'h80000000), labs, 1, 0, 2'd0, 32'hC, 0};
        vt[7] = '{mk(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000), labs, 1, 0, 2'd1, 32'h0, 0};
        vt[8] = '{mk(32'h00000001, 32'h7FFFFFFF, 0, 0), labs, 1, 0, 2'd2, 32'h0, 4};
        for (int n = 0; n < 9; n++) begin
            run_txn($sformatf("vec%0d", n), vt[n].x, vt[n].a, vt[n].mode, vt[n].dly,
                    n % 3, n % 2, vt[n].st, vt[n].lbl, vt[n].it);
        end

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0: rx[i] = 32'd0;
                    1: rx[i] = 32'h80000000;
                    default: begin
                        v = $urandom;
                        if (v[30:0] == 31'd0) v[0] = 1'b1;
                        rx[i] = v;
                    end
                endcase
                ra[i] = $urandom;
            end
            t = $urandom_range(0, 2);
            ref_model(rx, ra, t, est, elbl, eit, xf);
            run_txn($sformatf("rnd%0d", n), rx, ra, t, $urandom_range(0, 4),
                    $urandom_range(0, 3), 2, est, elbl, eit);
        end

        // Result backpressure with a new load beat already waiting.
        rsp_mode = 0; rsp_dly = 0;
        load(mk(0, 0, 32'h3F800000, 0), mk(32'h11, 32'h22, 32'h33, 32'h44), 0);
        wait_res("bp");
        in_valid = 1'b1; in_data = 32'h40400000; in_label = 32'h55;
        for (int i = 0; i < 10; i++) begin
            chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp.res_valid", {31'd0, res_valid}, 32'd1);
            chk("bp.label", res_label, 32'h33);
            chk("bp.status", {30'd0, res_status}, 32'd0);
            chk("bp.iter", {25'd0, res_iter}, 32'd0);
            chk("bp.lane0", x_bus[31:0], 32'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("bp.idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("bp.idle_res_valid", {31'd0, res_valid}, 32'd0);
        chk("bp.lane0_kept", x_bus[31:0], 32'd0);
        @(negedge clk);
        chk("bp.beat0_x", x_bus[31:0], 32'h40400000);
        chk("bp.beat0_a", a_bus[31:0], 32'h55);
        for (int k = 1; k < 4; k++) begin
            in_data = 32'd0;
            in_label = 32'h55 + 32'(k);
            chk("bp.reload_ready", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_res("bp2");
        chk("bp2.label", res_label, 32'h55);
        chk("bp2.status", {30'd0, res_status}, 32'd0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // Reset while waiting for upd_done; the late upd_done must be ignored.
        rsp_mode = 3; rsp_dly = 6;
        u0 = upd_cnt;
        load(mk(32'h3F800000, 32'h3F000000, 0, 0), labs, 0);
        t = 0;
        while (upd_cnt == u0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("mid.upd_started", upd_cnt - u0, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid.res_valid", {31'd0, res_valid}, 32'd0);
        chk("mid.in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid.x0", x_bus[31:0], 32'd0);
        chk("mid.a0", a_bus[31:0], 32'd0);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) chk("mid.late_x", x_bus[i*32 +: 32], 32'd0);
        chk("mid.late_ready", {31'd0, in_ready}, 32'd1);
        chk("mid.late_valid", {31'd0, res_valid}, 32'd0);
        chk("mid.no_restart", upd_cnt - u0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
